ariscv_imem_resp: RTL
=====================

ARISCV_IMEM_RESP -- requirements
Module: ariscv_imem_resp

Interface
REQ-001 SHALL have parameter INST_NBW, 32, instruction word width.
REQ-002 SHALL have parameter PC_NBW, 32, fetch address width.
REQ-003 SHALL have parameter DEPTH, 1024, number of instruction words (power of two, >=4).
REQ-004 SHALL have parameter WAIT_CYCLES, 1, wait states per access (0..15).
REQ-005 SHALL have port im_aclk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_async_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port i_req_valid  input  1  fetch requests a word.
REQ-008 SHALL have port o_req_ready  output  1  responder accepts a request.
REQ-009 SHALL have port i_req_pc  input  PC_NBW  byte address of requested instruction.
REQ-010 SHALL have port o_rsp_valid  output  1  response data valid.
REQ-011 SHALL have port i_rsp_ready  input  1  fetch consumes the response.
REQ-012 SHALL have port o_rsp_inst  output  INST_NBW  returned instruction.
REQ-013 SHALL have port o_rsp_pc  output  PC_NBW  address the response belongs to.
REQ-014 SHALL have port o_rsp_err  output  1  access fault flag, qualified by o_rsp_valid.
REQ-015 SHALL have ports i_wr_en input 1, i_wr_addr input PC_NBW, i_wr_data input INST_NBW: program-load write port.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL assert o_req_ready only in IDLE; a request is accepted when i_req_valid & o_req_ready at a rising edge (cycle T); address registered at T.
REQ-018 SHALL go IDLE->RESP when WAIT_CYCLES=0; otherwise IDLE->WAIT, loading a down-counter with WAIT_CYCLES-1, WAIT->RESP when counter is 0, decrementing each cycle.
REQ-019 SHALL assert o_rsp_valid exactly at cycle T+1+WAIT_CYCLES and hold o_rsp_valid, o_rsp_inst, o_rsp_pc, o_rsp_err stable until i_rsp_ready is sampled high.
REQ-020 SHALL go RESP->IDLE on i_rsp_ready; no new request is accepted in that same cycle (max one request per 2+WAIT_CYCLES cycles).
REQ-021 SHALL index memory with i_req_pc[$clog2(DEPTH)+1:2]; o_rsp_pc equals the accepted i_req_pc unmodified.
REQ-022 SHALL capture o_rsp_inst on the edge entering RESP; a write to the same word on that edge is not visible (old data returned), earlier writes are.
REQ-023 SHALL perform a write on any edge with i_wr_en high, in every state, word index from i_wr_addr[$clog2(DEPTH)+1:2]; writes with i_wr_addr >= DEPTH*4 are dropped.
REQ-024 SHALL ignore i_req_valid and i_req_pc outside IDLE.
REQ-025 SHALL deassert o_rsp_valid in IDLE and WAIT.

Reset
REQ-026 SHALL on rst_async_n low force state IDLE, counter 0, o_rsp_valid 0, o_rsp_inst 0, o_rsp_pc 0, o_rsp_err 0, regardless of state (in-flight access discarded).
REQ-027 SHALL leave memory contents unchanged by reset.
REQ-028 SHALL present o_req_ready 1 on the first edge after reset release.

Configuration
REQ-029 SHALL with ARISCV_IMEM_ERR_EN defined: set o_rsp_err=1 and o_rsp_inst=32'h0000_0013 (NOP) when i_req_pc[1:0]!=0 or i_req_pc >= DEPTH*4, memory not read.
REQ-030 SHALL without ARISCV_IMEM_ERR_EN: tie o_rsp_err to 0, ignore i_req_pc[1:0], wrap out-of-range addresses modulo DEPTH.

Structure
REQ-031 SHALL take the FSM state enum and the NOP constant (32'h0000_0013) from shared package ariscv_pkg.
REQ-032 SHALL place the storage array in sub-module ariscv_imem_array (one write port, one synchronous-capture read port); FSM and counter stay in top.

Verification
REQ-033 Write 0x00500093 to addr 0x8, WAIT_CYCLES=1, request pc 0x8 at T -> o_rsp_valid at T+2, inst 0x00500093, pc 0x8, err 0.
REQ-034 WAIT_CYCLES=0, request 0x0, i_rsp_ready low 3 cycles -> valid from T+1, outputs stable, o_req_ready 0 until handshake, IDLE next.
REQ-035 ERR_EN defined, request 0x6 then 0x1000 (DEPTH=1024) -> both err 1, inst 0x00000013; undefined -> err 0, data of word 1 and word 0.
REQ-036 Write 0xDEADBEEF to word 3 on RESP-entry edge for pc 0xC -> old data returned; next request to 0xC -> 0xDEADBEEF.
REQ-037 Assert rst_async_n low mid-WAIT (WAIT_CYCLES=3) -> outputs 0 immediately, o_req_ready 1 after release, memory preserved.

Source files
------------

// File: rtl/ariscv_pkg.sv
// Shared definitions for the instruction-memory responder: FSM states and the
// NOP word returned on access faults.
package ariscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/ariscv_imem_array.sv
// Instruction storage: one program-load write port, one read port that captures
// on the clock edge (a same-edge write to the same word returns the old data).
module ariscv_imem_array #(
  parameter int INST_NBW = 32,
  parameter int PC_NBW   = 32,
  parameter int DEPTH    = 1024
) (
  input  logic                       im_aclk,
  input  logic                       rst_async_n,
  input  logic                       wr_en,
  input  logic [PC_NBW-1:0]          wr_addr,
  input  logic [INST_NBW-1:0]        wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [INST_NBW-1:0]        rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [INST_NBW-1:0] mem [DEPTH];
  logic                wr_in_range;

  // Byte addresses at or beyond DEPTH*4 are dropped rather than wrapped.
  assign wr_in_range = (wr_addr >> (AW + 2)) == '0;

  always_ff @(posedge im_aclk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_addr[AW+1:2]] <= wr_data;
    end
  end

  always_ff @(posedge im_aclk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/ariscv_imem_resp.sv
// Instruction-memory responder with programmable wait states.
// Optional ARISCV_IMEM_ERR_EN: fault misaligned/out-of-range fetches with a NOP.
module ariscv_imem_resp
  import ariscv_pkg::*;
#(
  parameter int INST_NBW    = 32,
  parameter int PC_NBW      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                im_aclk,
  input  logic                rst_async_n,
  // Request: accepted on a rising edge with i_req_valid & o_req_ready (IDLE only).
  // Response: o_rsp_valid and its payload hold until i_rsp_ready is sampled high.
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [PC_NBW-1:0]   i_req_pc,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [INST_NBW-1:0] o_rsp_inst,
  output logic [PC_NBW-1:0]   o_rsp_pc,
  output logic                o_rsp_err,
  input  logic                i_wr_en,
  input  logic [PC_NBW-1:0]   i_wr_addr,
  input  logic [INST_NBW-1:0] i_wr_data,
  output logic [1:0]          dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  imem_state_e         state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [PC_NBW-1:0]   pc_q;
  logic                err_q;
  logic                accept;
  logic                enter_resp;
  logic                req_err;
  logic                err_sel;
  logic [AW-1:0]       rd_idx;
  logic [INST_NBW-1:0] rd_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge im_aclk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        pc_q  <= i_req_pc;
        err_q <= req_err;
      end
    end
  end

  assign accept     = (state_q == IDLE) && i_req_valid;
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

`ifdef ARISCV_IMEM_ERR_EN
  assign req_err = (i_req_pc[1:0] != 2'b00) || ((i_req_pc >> (AW + 2)) != '0);
`else
  assign req_err = 1'b0;
`endif

  // With zero wait states RESP is entered on the accept edge, so read from the live request.
  assign err_sel = (state_q == IDLE) ? req_err : err_q;
  assign rd_idx  = (state_q == IDLE) ? i_req_pc[AW+1:2] : pc_q[AW+1:2];

  ariscv_imem_array #(
    .INST_NBW (INST_NBW),
    .PC_NBW   (PC_NBW),
    .DEPTH    (DEPTH)
  ) u_array (
    .im_aclk     (im_aclk),
    .rst_async_n (rst_async_n),
    .wr_en       (i_wr_en),
    .wr_addr     (i_wr_addr),
    .wr_data     (i_wr_data),
    .rd_en       (enter_resp && !err_sel),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data)
  );

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_inst  = err_q ? INST_NBW'(NOP_INST) : rd_data;
  assign o_rsp_pc    = pc_q;
  assign o_rsp_err   = err_q;
  assign dbg_state   = state_q;

endmodule
